// File: rtl/fir_dma_ctrl_pkg.sv
// Shared types for the FIR DMA controller: FSM states, RAM grant encoding, sample width.
package fir_ctrl_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_FWR,
      GNT_FRD,
      GNT_CPU
   } gnt_t;

endpackage

// File: rtl/fir_dma_ctrl_arb.sv
// fir_mem_arb: combinational fixed-priority grant (buffered FIR write > FIR read > CPU)
// and single-port RAM mux; at most one access per cycle.
module fir_mem_arb
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output gnt_t              gnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);

   always_comb begin
      gnt       = GNT_NONE;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (wr_req) begin
         gnt       = GNT_FWR;
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else if (rd_req) begin
         gnt      = GNT_FRD;
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end else if (cpu_req) begin
         gnt       = GNT_CPU;
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_we ? cpu_wdata : '0;
      end
   end

endmodule

// File: rtl/fir_dma_ctrl.sv
// fir_dma_ctrl: sequences the FIR engine over a RAM block and shares the RAM with the CPU.
// Optional FIR_DMA_IRQ_EN adds a sticky irq output with an irq_clr input.
module fir_dma_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
`ifdef FIR_DMA_IRQ_EN
   input  logic              irq_clr,
   output logic              irq,
`endif
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [LEN_W-1:0]  cfg_len,
   output logic              busy,
   output logic              done,
   output logic              fir_en,
   output logic              read_quit,
   input  logic              read_req,
   output logic              read_ready,
   output logic [DATA_W-1:0] read_data,
   input  logic              write_req,
   input  logic [DATA_W-1:0] write_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state, state_nx;
   gnt_t              gnt;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [LEN_W-1:0]  len_q, rd_idx, wr_idx;
   logic              wbuf_valid;
   logic [ADDR_W-1:0] wbuf_addr;
   logic [DATA_W-1:0] wbuf_data;
   logic              rd_s1, rd_s2, aborting, cpu_rd_s1;
   logic              abort_now, rd_elig, cpu_elig;

   assign abort_now = aborting | ((state == RUN) & cfg_abort);
   assign rd_elig   = (state == RUN) & read_req & ~rd_s1 & ~rd_s2 & (rd_idx < len_q) & ~abort_now;
   // reset gating keeps the RAM port quiet while the synchronous reset is applied
   assign cpu_elig  = reset & cpu_req & ~cpu_rd_s1 & ~cpu_ready;

   fir_mem_arb #(
      .ADDR_W (ADDR_W)
   ) u_arb (
      .wr_req    (wbuf_valid),
      .wr_addr   (wbuf_addr),
      .wr_data   (wbuf_data),
      .rd_req    (rd_elig),
      .rd_addr   (src_q + ADDR_W'(rd_idx)),
      .cpu_req   (cpu_elig),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .gnt       (gnt),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      fir_en    = 1'b0;
      read_quit = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start && !cfg_abort)
               state_nx = (cfg_len != '0) ? RUN : DONE;
         end
         RUN: begin
            busy   = 1'b1;
            fir_en = 1'b1;
            // leave only once the last write has landed and no read is in flight
            if ((wr_idx == len_q || abort_now) && !wbuf_valid && !write_req && !rd_s1 && !rd_s2)
               state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            read_quit = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         rd_idx     <= '0;
         wr_idx     <= '0;
         wbuf_valid <= 1'b0;
         wbuf_addr  <= '0;
         wbuf_data  <= '0;
         rd_s1      <= 1'b0;
         rd_s2      <= 1'b0;
         aborting   <= 1'b0;
         read_ready <= 1'b0;
         read_data  <= '0;
         cpu_rd_s1  <= 1'b0;
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         state    <= state_nx;
         aborting <= (state == RUN) && (state_nx == RUN) && abort_now;
         if (state == IDLE && state_nx == RUN) begin
            src_q  <= cfg_src;
            dst_q  <= cfg_dst;
            len_q  <= cfg_len;
            rd_idx <= '0;
            wr_idx <= '0;
         end
         if (gnt == GNT_FWR)
            wbuf_valid <= 1'b0;
         if (state == RUN && write_req) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= dst_q + ADDR_W'(wr_idx);
            wbuf_data  <= write_data;
            wr_idx     <= wr_idx + LEN_W'(1);
         end
         if (gnt == GNT_FRD)
            rd_idx <= rd_idx + LEN_W'(1);
         rd_s1      <= (gnt == GNT_FRD);
         rd_s2      <= rd_s1;
         read_ready <= rd_s1 && !abort_now;
         if (rd_s1)
            read_data <= mem_rdata;
         cpu_rd_s1 <= (gnt == GNT_CPU) && !cpu_we;
         cpu_ready <= ((gnt == GNT_CPU) && cpu_we) || cpu_rd_s1;
         if (cpu_rd_s1)
            cpu_rdata <= mem_rdata;
      end
   end

`ifdef FIR_DMA_IRQ_EN
   always_ff @(posedge clk) begin
      if (!reset)
         irq <= 1'b0;
      else if (state_nx == DONE)
         irq <= 1'b1;
      else if (irq_clr)
         irq <= 1'b0;
   end
`endif

endmodule
